vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_pixel_enable.sv | 48 ++++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, controller state type and geometry helpers
// shared by the raster timing generator and its pixel-enable divider.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vga_state_t;

    // Total pixels per line or lines per frame.
    function automatic int total_of(input int visible, input int front,
                                    input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    // Counter width able to hold 0..total-1 (never narrower than one bit).
    function automatic int width_of(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_pixel_enable.sv
// vga_pixel_enable: integer clock divider producing the one-clk pixel enable.
// The count restarts at 0 on the first RUN clk so pixel (0,0) always gets a
// full CLK_DIV period. pix_en_next is the lookahead the top uses to register
// its pixel strobes in the same cycle as pix_en.
module vga_pixel_enable
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 1
)
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic pix_en,
    output logic pix_en_next
);

    localparam int                DIV_W    = width_of(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    // Next divider value: zero while parked or on the first RUN clk, else wrap at CLK_DIV-1.
    always_comb begin
        div_next = '0;
        if (run && active && (div_cnt != DIV_LAST)) begin
            div_next = div_cnt + 1'b1;
        end
    end

    assign pix_en_next = run && (div_next == DIV_LAST);

    // Divider, run tracking and registered pixel enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active  <= 1'b0;
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            active  <= run;
            div_cnt <= div_next;
            pix_en  <= pix_en_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with run/park control.
// Build macro VGA_FRAME_COUNT_EN adds a 16-bit frame_count output.
//
//   state | meaning
//   IDLE  | parked: position at origin, outputs at reset values
//   RUN   | raster advancing one pixel per pix_en
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CLK_DIV    = 1,
    localparam int H_TOTAL   = total_of(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL   = total_of(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
    localparam int X_W       = width_of(H_TOTAL),
    localparam int Y_W       = width_of(V_TOTAL)
)
(
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    output logic           pix_en,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic           line_start,
    output logic           frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]    frame_count
`endif
);

    // Every region bound fits the counter: the back porch keeps sync ends below the total.
    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] X_VIS    = X_W'(H_VISIBLE);
    localparam logic [X_W-1:0] HS_BEGIN = X_W'(H_VISIBLE + H_FRONT);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_VIS    = Y_W'(V_VISIBLE);
    localparam logic [Y_W-1:0] VS_BEGIN = Y_W'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_VISIBLE + V_FRONT + V_SYNC);

    generate
        if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
            CLK_DIV < 1) begin : g_bad_params
            $error("vga_timing_gen: porch/sync/visible sizes and CLK_DIV must all be >= 1");
        end
    endgenerate

    vga_state_t     state;
    vga_state_t     state_next;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic           pix_en_next;
    logic           run_next;
    logic           h_active;
    logic           v_active;
    logic           visible_next;

    vga_pixel_enable #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_enable (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pix_en      (pix_en),
        .pix_en_next (pix_en_next)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and next raster position; parking always returns to the origin.
    always_comb begin
        state_next = IDLE;
        x_next     = '0;
        y_next     = '0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (run) begin
                    state_next = RUN;
                    x_next     = pos_x;
                    y_next     = pos_y;
                    if (pix_en) begin
                        if (pos_x == X_LAST) begin
                            x_next = '0;
                            y_next = (pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
                        end else begin
                            x_next = pos_x + 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Region decodes from the next position so registered outputs line up with pos_x/pos_y.
    always_comb begin
        run_next     = (state_next == RUN);
        h_active     = run_next && (x_next >= HS_BEGIN) && (x_next < HS_END);
        v_active     = run_next && (y_next >= VS_BEGIN) && (y_next < VS_END);
        visible_next = run_next && (x_next < X_VIS) && (y_next < Y_VIS);
    end

    // Registered position, syncs, blanking and pixel strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x       <= '0;
            pos_y       <= '0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pos_x       <= x_next;
            pos_y       <= y_next;
            hsync       <= h_active ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= v_active ? V_SYNC_POL : ~V_SYNC_POL;
            display_on  <= visible_next;
            line_start  <= pix_en_next && (x_next == '0);
            frame_start <= pix_en_next && (x_next == '0) && (y_next == '0);
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Completed frames: bumps when the last pixel wraps to the origin; parking holds it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (state == RUN && run && pix_en && pos_x == X_LAST && pos_y == Y_LAST) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three raster geometries driven with randomised run/park
// and reset activity. A reference model derives every output from elapsed RUN
// clocks with plain arithmetic; a monitor pops and compares once per clk.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        pe;
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } out_t;
    typedef out_t [2:0] trio_t;

    // Raster 0: default 640x480, raster 1: tiny /3, raster 2: inverted syncs /2.
    localparam int HV[3]  = '{640, 4, 5};
    localparam int HF[3]  = '{16, 1, 2};
    localparam int HS[3]  = '{96, 2, 3};
    localparam int HB[3]  = '{48, 1, 2};
    localparam int VV[3]  = '{480, 3, 4};
    localparam int VF[3]  = '{10, 1, 2};
    localparam int VS[3]  = '{2, 1, 2};
    localparam int VB[3]  = '{33, 1, 1};
    localparam int DIV[3] = '{1, 3, 2};
    localparam bit HP[3]  = '{1'b0, 1'b0, 1'b1};
    localparam bit VP[3]  = '{1'b0, 1'b0, 1'b1};
`ifdef VGA_FRAME_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] run;

    logic       d0_pe, d0_hs, d0_vs, d0_de, d0_ls, d0_fs;
    logic [9:0] d0_x, d0_y;
    logic       d1_pe, d1_hs, d1_vs, d1_de, d1_ls, d1_fs;
    logic [2:0] d1_x, d1_y;
    logic       d2_pe, d2_hs, d2_vs, d2_de, d2_ls, d2_fs;
    logic [3:0] d2_x, d2_y;
    logic [15:0] d0_fc, d1_fc, d2_fc;

    int    n_vec = 0;
    int    n_bad = 0;
    int    preload_seq = 0;
    int    preload_seen = 0;
    trio_t sb_q[$];

    int          t_m[3];
    bit          on_m[3];
    logic [15:0] fc_m[3];

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .run(run[0]), .pix_en(d0_pe), .pos_x(d0_x), .pos_y(d0_y),
        .hsync(d0_hs), .vsync(d0_vs), .display_on(d0_de), .line_start(d0_ls), .frame_start(d0_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(d0_fc)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(HV[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
        .V_VISIBLE(VV[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]),
        .H_SYNC_POL(HP[1]), .V_SYNC_POL(VP[1]), .CLK_DIV(DIV[1])
    ) u_tiny (
        .clk(clk), .reset(reset), .run(run[1]), .pix_en(d1_pe), .pos_x(d1_x), .pos_y(d1_y),
        .hsync(d1_hs), .vsync(d1_vs), .display_on(d1_de), .line_start(d1_ls), .frame_start(d1_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(d1_fc)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(HV[2]), .H_FRONT(HF[2]), .H_SYNC(HS[2]), .H_BACK(HB[2]),
        .V_VISIBLE(VV[2]), .V_FRONT(VF[2]), .V_SYNC(VS[2]), .V_BACK(VB[2]),
        .H_SYNC_POL(HP[2]), .V_SYNC_POL(VP[2]), .CLK_DIV(DIV[2])
    ) u_pol (
        .clk(clk), .reset(reset), .run(run[2]), .pix_en(d2_pe), .pos_x(d2_x), .pos_y(d2_y),
        .hsync(d2_hs), .vsync(d2_vs), .display_on(d2_de), .line_start(d2_ls), .frame_start(d2_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(d2_fc)
`endif
    );

`ifndef VGA_FRAME_COUNT_EN
    assign d0_fc = '0;
    assign d1_fc = '0;
    assign d2_fc = '0;
`endif

    always #5 clk = ~clk;

    // Expected outputs for raster i after t clocks of RUN (on=0: parked/reset values).
    function automatic out_t expect_out(input int i, input bit on, input int t, input logic [15:0] fc);
        out_t r;
        int   ht, vt, p, x, y;
        bit   pe;
        ht   = HV[i] + HF[i] + HS[i] + HB[i];
        vt   = VV[i] + VF[i] + VS[i] + VB[i];
        r    = '0;
        r.hs = ~HP[i];
        r.vs = ~VP[i];
        if (on) begin
            p    = t / DIV[i];
            x    = p % ht;
            y    = (p / ht) % vt;
            pe   = (t % DIV[i]) == DIV[i] - 1;
            r.x  = 16'(x);
            r.y  = 16'(y);
            r.pe = pe;
            r.hs = (x >= HV[i] + HF[i] && x < HV[i] + HF[i] + HS[i]) ? HP[i] : ~HP[i];
            r.vs = (y >= VV[i] + VF[i] && y < VV[i] + VF[i] + VS[i]) ? VP[i] : ~VP[i];
            r.de = (x < HV[i]) && (y < VV[i]);
            r.ls = pe && (x == 0);
            r.fs = pe && (x == 0) && (y == 0);
        end
        r.fc = FC_EN ? fc : 16'd0;
        return r;
    endfunction

    function automatic int frame_clks(input int i);
        return (HV[i] + HF[i] + HS[i] + HB[i]) * (VV[i] + VF[i] + VS[i] + VB[i]) * DIV[i];
    endfunction

    function automatic out_t pack_out(input int x, input int y, input logic pe, input logic hs,
                                      input logic vs, input logic de, input logic ls,
                                      input logic fs, input logic [15:0] fc);
        out_t r;
        r = '{x: 16'(x), y: 16'(y), pe: pe, hs: hs, vs: vs, de: de, ls: ls, fs: fs, fc: fc};
        return r;
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got x=%0d y=%0d pe=%b hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d pe=%b hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     name, $time, act.x, act.y, act.pe, act.hs, act.vs, act.de, act.ls, act.fs, act.fc,
                     exp.x, exp.y, exp.pe, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s @%0t: got wait expired, want condition reached", name, $time);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: tracks RUN time per raster and queues the expected outputs.
    always @(posedge clk) begin : model
        trio_t e;
        if (preload_seq != preload_seen) begin
            fc_m[1]      = 16'hFFFF;
            preload_seen = preload_seq;
        end
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                on_m[i] = 1'b0;
                t_m[i]  = 0;
                fc_m[i] = 16'd0;
            end else if (run[i]) begin
                if (on_m[i]) begin
                    t_m[i]++;
                    if (t_m[i] % frame_clks(i) == 0) fc_m[i]++;
                end else begin
                    on_m[i] = 1'b1;
                    t_m[i]  = 0;
                end
            end else begin
                on_m[i] = 1'b0;
                t_m[i]  = 0;
            end
            e[i] = expect_out(i, on_m[i], t_m[i], fc_m[i]);
        end
        sb_q.push_back(e);
    end

    // Monitor: every clk the DUTs present a full output set; compare on the falling edge.
    always @(negedge clk) begin : monitor
        trio_t e;
        out_t  a[3];
        if (sb_q.size() > 0) begin
            e    = sb_q.pop_front();
            a[0] = pack_out(int'(d0_x), int'(d0_y), d0_pe, d0_hs, d0_vs, d0_de, d0_ls, d0_fs, d0_fc);
            a[1] = pack_out(int'(d1_x), int'(d1_y), d1_pe, d1_hs, d1_vs, d1_de, d1_ls, d1_fs, d1_fc);
            a[2] = pack_out(int'(d2_x), int'(d2_y), d2_pe, d2_hs, d2_vs, d2_de, d2_ls, d2_fs, d2_fc);
            for (int i = 0; i < 3; i++) begin
                if (reset) e[i] = expect_out(i, 1'b0, 0, 16'd0);
                check_out($sformatf("scoreboard_raster%0d", i), a[i], e[i]);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got time limit, want summary reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset = 1'b1;
        run   = 3'b000;
        step(3);
        reset = 1'b0;
        step(2);

        // Free run: several default lines, many tiny/inverted frames.
        run = 3'b111;
        step(2500);

        // Park the tiny raster mid-frame, then restart it.
        n = 0;
        while (!(d1_x == 3'd2 && d1_y == 3'd1) && n < 200) begin
            step(1);
            n++;
        end
        if (n >= 200) timeout_fail("wait_tiny_pos_2_1");
        run[1] = 1'b0;
        step(1);
        check_val("park_pos_x", int'(d1_x), 0);
        check_val("park_pos_y", int'(d1_y), 0);
        check_val("park_display_on", int'(d1_de), 0);
        check_val("park_hsync", int'(d1_hs), 1);
        check_val("park_vsync", int'(d1_vs), 1);
        step(1);
        run[1] = 1'b1;
        step(20);

        // Random run/park activity, including single-clk toggles.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 99) < 2) run[i] = ~run[i];
            end
            step(1);
        end
        run = 3'b111;
        step(5);

        // Asynchronous reset while the default raster is inside hsync.
        n = 0;
        while (d0_hs !== 1'b0 && n < 1000) begin
            step(1);
            n++;
        end
        if (n >= 1000) timeout_fail("wait_default_hsync");
        reset = 1'b1;
        #1;
        check_val("async_reset_hsync", int'(d0_hs), 1);
        check_val("async_reset_pos_x", int'(d0_x), 0);
        check_val("async_reset_pol_hsync", int'(d2_hs), 0);
        check_val("async_reset_pol_vsync", int'(d2_vs), 0);
        step(2);
        reset = 1'b0;
        step(1000);

`ifdef VGA_FRAME_COUNT_EN
        reset = 1'b1;
        run   = 3'b000;
        step(2);
        reset = 1'b0;
        run   = 3'b111;
        step(3 * 144 + 1);
        check_val("frame_count_three", int'(d1_fc), 3);
        @(negedge clk);
        #1;
        force u_tiny.frame_count = 16'hFFFF;
        preload_seq++;
        #1;
        release u_tiny.frame_count;
        step(1);
        n = 0;
        while (d1_fc == 16'hFFFF && n < 300) begin
            step(1);
            n++;
        end
        if (n >= 300) timeout_fail("wait_frame_count_wrap");
        check_val("frame_count_wrap", int'(d1_fc), 0);
        step(50);
`endif

        step(3);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
